freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency counter clocked from the 12 MHz board clock `hwclk`. It counts rising edges of an asynchronous, slower signal `sig_in` over a fixed window of `GATE_CYCLES` `hwclk` cycles and publishes the count with a one-cycle valid strobe. Typical sources are a scaler output or a PLL-derived clock divided below `hwclk`/2. Use it to check scaler and PLL settings on hardware, for example by driving the result onto LEDs.

## Interface
Parameters:
- `GATE_CYCLES`, default 12000000: window length in `hwclk` cycles (1 s at 12 MHz). Minimum 2.
- `CNT_W`, default 24: width of the edge counter and the result.

Ports:
- `hwclk`, input, 1: the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `sig_in`, input, 1: asynchronous signal to measure. Must be below `hwclk`/2 and have a high time and low time of at least 1 `hwclk` cycle each.
- `start`, input, 1: single-shot request. Sampled only while idle.
- `continuous`, input, 1: level input. While high, windows run back-to-back.
- `busy`, output, 1: high while a window is in progress.
- `count`, output, `CNT_W`: edge count from the last completed window. Held until the next result.
- `count_valid`, output, 1: one-cycle pulse when `count` updates.
- `overflow`, output, 1: set when the last window saturated. Updates together with `count`.

## Operation
- **Front end:** two-flop synchronizer on `sig_in` (s1, s2) followed by a delay flop s3. An edge is `s2 & ~s3`. All three flops reset to 0.
- **State machine states:** IDLE and GATE.
- **IDLE:**
  - If `start` or `continuous` is high: load the gate counter with `GATE_CYCLES`-1, clear the edge counter, go to GATE.
  - Otherwise stay in IDLE.
- **GATE:**
  - Every detected edge increments the edge counter.
  - The counter saturates at 2^`CNT_W`-1. An increment attempted at saturation sets the sticky window-overflow flag.
  - The gate counter decrements each cycle.
- **Final gate cycle (gate counter = 0):**
  - The edge detected in that cycle is included in the result.
  - Next cycle: `count` takes the final value, `overflow` takes the window flag, and `count_valid` pulses.
  - If `continuous` is high in the final cycle: stay in GATE, reload the gate counter, and restart the edge counter. The publish cycle is the first cycle of the new window, so no edge is lost or double-counted.
  - If `continuous` is low: go to IDLE.
- **Ignored inputs:** `start` while `busy` has no effect. Dropping `continuous` mid-window lets that window finish.
- **Reset:**
  - Aborts any window with no `count_valid`.
  - Resets the state to IDLE and all counters to 0.
  - Resets `busy`, `count`, `count_valid` and `overflow` to 0.
- **Widths:**
  - Gate counter is `$clog2(GATE_CYCLES)` bits.
  - Edge counter is `CNT_W` bits with a saturating add, never wrapping.
  - `CNT_W` of at least `$clog2(GATE_CYCLES/2+1)` guarantees no saturation.

## Timing
- `start` sampled high in IDLE at cycle T:
  - `busy` = 1 from T+1.
  - Gate cycles are T+1 through T+`GATE_CYCLES`.
  - `count_valid` = 1 at T+`GATE_CYCLES`+1.
  - In single-shot mode, `busy` = 0 at T+`GATE_CYCLES`+1.
- A `sig_in` rising edge that meets setup before cycle k is detected at cycle k+2. Only edges detected during gate cycles count.
- Continuous mode: `count_valid` pulses exactly `GATE_CYCLES` cycles apart, and `busy` stays high.
- `rst` high at cycle R: every output is at its reset value at R+1.

## Structure
- **Shared package `freq_meter_pkg`:**
  - State enum `fm_state_t` (IDLE, GATE).
  - A localparam helper giving the gate counter width.
- **Sub-module `sync_edge`:**
  - Contains the 2-flop synchronizer, the delay flop and the rising-edge output.
  - Has its own synchronous active-high reset.
  - Is reusable for button inputs elsewhere in the design.

## Test plan
Bench parameters: `GATE_CYCLES`=100, `CNT_W`=8 unless stated.
- **Single shot:** after reset, hold `sig_in` low and pulse `start` -> `count_valid` once, 101 cycles after `start`; `count`=0, `overflow`=0, `busy` low afterwards.
- **Period 10:** `sig_in` with a 10-cycle period (5 high / 5 low), single shot -> `count`=10 (±0 for phase-aligned stimulus), `overflow`=0.
- **Continuous:** period-4 stimulus, `continuous`=1 for 3 windows -> three `count_valid` pulses exactly 100 cycles apart, each with `count`=25; `busy` never drops between windows. Then drop `continuous` mid-window 4 -> a fourth result arrives, then `busy`=0.
- **Overflow:** rebuild with `CNT_W`=4, period-4 stimulus, single shot -> `count`=15, `overflow`=1. Next window with `sig_in` low -> `count`=0, `overflow`=0.
- **Reset mid-window:** assert `rst` at gate cycle 50 -> no `count_valid`; `busy`, `count` and `overflow` are 0 on the next cycle. A following `start` gives a correct fresh result.
- **Ignored start:** pulse `start` repeatedly while `busy` -> the window length is unchanged (`count_valid` 101 cycles after the first `start`) and only one result is produced.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

   // Measurement controller states: waiting for a request, or counting inside a gate window.
   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } fm_state_t;

   // Number of flops in the sig_in front end (two synchronizer flops plus one delay flop).
   localparam int SYNC_STAGES = 3;

   // Width of the gate down-counter. It only ever holds GATE_CYCLES-1 down to 0,
   // and it is kept at least one bit wide.
   function automatic int fm_gate_w(input int gate_cycles);
      int w;
      w = $clog2(gate_cycles);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus delay flop with a one-cycle rising-edge output.
// Reusable for any slow asynchronous level, such as a push button.
module sync_edge
   import freq_meter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   // stage_reg[0] = s1, stage_reg[1] = s2, stage_reg[2] = s3 (delay flop)
   logic [SYNC_STAGES-1:0] stage_reg;

   // Shift the asynchronous input through the synchronizer and delay flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= {stage_reg[SYNC_STAGES-2:0], async_in};
      end
   end

   // A rising edge is seen when the synchronized level is high and the delayed copy is still low.
   always_comb begin
      rise = stage_reg[1] & ~stage_reg[2];
   end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES hwclk cycles
// and publishes the result with a one-cycle valid strobe.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 12000000,
   parameter int CNT_W       = 24
)
(
   input  logic             hwclk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             overflow
);

   localparam int             GW        = fm_gate_w(GATE_CYCLES);
   localparam logic [GW-1:0]  GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fm_state_t        state_reg, state_next;
   logic [GW-1:0]    gate_cnt_reg, gate_cnt_next;
   logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
   logic             win_ovf_reg, win_ovf_next;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic             count_valid_reg;

   logic             sig_rise;
   logic             launch;
   logic             final_cycle;
   logic             at_max;
   logic [CNT_W-1:0] sum_cnt;
   logic             sum_ovf;

   sync_edge u_sync_edge (
      .clk      (hwclk),
      .rst      (rst),
      .async_in (sig_in),
      .rise     (sig_rise)
   );

   // Decode window start / window end and build the saturating edge sum for this cycle.
   always_comb begin
      launch      = (state_reg == IDLE) && (start || continuous);
      final_cycle = (state_reg == GATE) && (gate_cnt_reg == '0);
      at_max      = (edge_cnt_reg == CNT_MAX);
      sum_cnt     = (sig_rise && !at_max) ? edge_cnt_reg + CNT_W'(1) : edge_cnt_reg;
      sum_ovf     = win_ovf_reg | (sig_rise & at_max);
   end

   // State register.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a window ends back in IDLE unless continuous is still requested.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (launch) begin
               state_next = GATE;
            end
         end
         GATE: begin
            if (final_cycle && !continuous) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: busy simply reflects being inside a window.
   always_comb begin
      busy        = (state_reg == GATE);
      count       = count_reg;
      count_valid = count_valid_reg;
      overflow    = overflow_reg;
   end

   // Gate and edge counter next values. In continuous mode the final cycle reloads both,
   // so the publish cycle becomes the first counting cycle of the next window.
   always_comb begin
      gate_cnt_next = gate_cnt_reg;
      edge_cnt_next = edge_cnt_reg;
      win_ovf_next  = win_ovf_reg;
      if (launch) begin
         gate_cnt_next = GATE_LOAD;
         edge_cnt_next = '0;
         win_ovf_next  = 1'b0;
      end else if (state_reg == GATE) begin
         if (final_cycle) begin
            if (continuous) begin
               gate_cnt_next = GATE_LOAD;
               edge_cnt_next = '0;
               win_ovf_next  = 1'b0;
            end else begin
               edge_cnt_next = sum_cnt;
               win_ovf_next  = sum_ovf;
            end
         end else begin
            gate_cnt_next = gate_cnt_reg - GW'(1);
            edge_cnt_next = sum_cnt;
            win_ovf_next  = sum_ovf;
         end
      end
   end

   // Counter registers and result publishing; the final cycle's own edge is part of the result.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         gate_cnt_reg    <= '0;
         edge_cnt_reg    <= '0;
         win_ovf_reg     <= 1'b0;
         count_reg       <= '0;
         overflow_reg    <= 1'b0;
         count_valid_reg <= 1'b0;
      end else begin
         gate_cnt_reg    <= gate_cnt_next;
         edge_cnt_reg    <= edge_cnt_next;
         win_ovf_reg     <= win_ovf_next;
         count_valid_reg <= final_cycle;
         if (final_cycle) begin
            count_reg    <= sum_cnt;
            overflow_reg <= sum_ovf;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate: one 8-bit and one 4-bit instance.
module tb_freq_meter;

   localparam int G = 100;

   logic       hwclk = 1'b0;
   logic       rst;
   logic       sig_in;
   logic       start;
   logic       continuous;
   logic       start2;
   logic       cont2;

   logic       busy1;
   logic [7:0] count1;
   logic       valid1;
   logic       ovf1;

   logic       busy2;
   logic [3:0] count2;
   logic       valid2;
   logic       ovf2;

   int checks = 0;
   int errors = 0;
   int period = 0;
   int ph     = 0;
   int n;
   bit bd;

   always #5 hwclk = ~hwclk;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut (
      .hwclk       (hwclk),
      .rst         (rst),
      .sig_in      (sig_in),
      .start       (start),
      .continuous  (continuous),
      .busy        (busy1),
      .count       (count1),
      .count_valid (valid1),
      .overflow    (ovf1)
   );

   freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
      .hwclk       (hwclk),
      .rst         (rst),
      .sig_in      (sig_in),
      .start       (start2),
      .continuous  (cont2),
      .busy        (busy2),
      .count       (count2),
      .count_valid (valid2),
      .overflow    (ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: sample point is 1 time unit after the rising edge; sig_in stimulus advances here.
   task automatic tick();
      @(posedge hwclk);
      #1;
      if (period == 0) begin
         ph     = 0;
         sig_in = 1'b0;
      end else begin
         ph     = (ph + 1) % period;
         sig_in = (ph < period / 2);
      end
   endtask

   // Tick until the selected instance strobes count_valid or the budget runs out.
   task automatic wait_valid(input bit sel, input bit spam, input int limit,
                             output int cnt, output bit busy_dropped);
      cnt          = 0;
      busy_dropped = 1'b0;
      while (cnt < limit) begin
         start = (spam && (cnt % 10 == 5)) ? 1'b1 : 1'b0;
         tick();
         cnt++;
         if ((sel ? valid2 : valid1) === 1'b1) break;
         if ((sel ? busy2 : busy1) !== 1'b1) busy_dropped = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      sig_in     = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      start2     = 1'b0;
      cont2      = 1'b0;
      repeat (3) tick();
      chk("rst_busy",   busy1,  0);
      chk("rst_count",  count1, 0);
      chk("rst_valid",  valid1, 0);
      chk("rst_ovf",    ovf1,   0);
      chk("rst4_busy",  busy2,  0);
      chk("rst4_count", count2, 0);
      chk("rst4_valid", valid2, 0);
      chk("rst4_ovf",   ovf2,   0);
      rst = 1'b0;
      tick();

      // Single shot with sig_in held low
      start = 1'b1; tick(); start = 1'b0;
      chk("ss_busy_on", busy1, 1);
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("ss_latency", n + 1, 101);
      chk("ss_count",   count1, 0);
      chk("ss_ovf",     ovf1, 0);
      chk("ss_busy_off", busy1, 0);
      chk("ss_no_drop", bd, 0);
      tick();
      chk("ss_valid_1cyc", valid1, 0);

      // Period 10 single shot
      period = 10;
      repeat (20) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("p10_latency", n + 1, 101);
      chk("p10_count",   count1, 10);
      chk("p10_ovf",     ovf1, 0);

      // Continuous, period 4
      period = 4;
      repeat (20) tick();
      continuous = 1'b1; tick();
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("cont1_latency", n + 1, 101);
      chk("cont1_count",   count1, 25);
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("cont2_spacing", n, 100);
      chk("cont2_count",   count1, 25);
      chk("cont2_busy",    bd, 0);
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("cont3_spacing", n, 100);
      chk("cont3_count",   count1, 25);
      chk("cont3_busy",    bd, 0);
      chk("cont3_busy_at_pub", busy1, 1);
      repeat (30) tick();
      continuous = 1'b0;
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("cont4_spacing", n + 30, 100);
      chk("cont4_count",   count1, 25);
      chk("cont4_busy_off", busy1, 0);

      // Overflow on the 4-bit instance
      start2 = 1'b1; tick(); start2 = 1'b0;
      wait_valid(1'b1, 1'b0, 150, n, bd);
      chk("ovf_latency", n + 1, 101);
      chk("ovf_count",   count2, 15);
      chk("ovf_flag",    ovf2, 1);
      period = 0;
      repeat (10) tick();
      start2 = 1'b1; tick(); start2 = 1'b0;
      wait_valid(1'b1, 1'b0, 150, n, bd);
      chk("ovf_clr_count", count2, 0);
      chk("ovf_clr_flag",  ovf2, 0);

      // Reset in the middle of a window
      period = 4;
      repeat (10) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (49) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_busy",  busy1, 0);
      chk("mid_rst_count", count1, 0);
      chk("mid_rst_ovf",   ovf1, 0);
      chk("mid_rst_valid", valid1, 0);
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("mid_rst_no_result", n, 150);
      start = 1'b1; tick(); start = 1'b0;
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("post_rst_latency", n + 1, 101);
      chk("post_rst_count",   count1, 25);

      // Start pulses during a window are ignored
      start = 1'b1; tick(); start = 1'b0;
      wait_valid(1'b0, 1'b1, 150, n, bd);
      chk("ign_latency", n + 1, 101);
      chk("ign_count",   count1, 25);
      wait_valid(1'b0, 1'b0, 150, n, bd);
      chk("ign_single_result", n, 150);
      chk("ign_idle", busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
